// File: rtl/cnn_class_decoder.sv
// Output stage of the cnn datapath: decodes the signed argmax of a frame of
// per-class scores and presents it on a valid/ready result port.
module cnn_class_decoder #(
    parameter int NUM_CLASSES = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int IDX_WIDTH   = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                         clk,
    input  logic                         rstb,
    input  logic                         score_valid,
    output logic                         score_ready,
    input  logic signed [DATA_WIDTH-1:0] score_data,
    input  logic                         score_last,
    output logic                         class_valid,
    input  logic                         class_ready,
    output logic [IDX_WIDTH-1:0]         class_idx,
    output logic [DATA_WIDTH-1:0]        class_score,
    output logic                         class_err,
    output logic [CNT_WIDTH-1:0]         frame_count
);

    // Beat counter must reach NUM_CLASSES+1 so long frames stay distinguishable.
    localparam int BW = $clog2(NUM_CLASSES + 2);

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t                       state_r;
    logic [BW-1:0]                beat_cnt_r;
    logic signed [DATA_WIDTH-1:0] best_r;
    logic [IDX_WIDTH-1:0]         best_idx_r;
    logic                         ovf_r;

    logic                         accept_s;
    logic signed [DATA_WIDTH-1:0] next_best_s;
    logic [IDX_WIDTH-1:0]         next_idx_s;
    logic                         next_ovf_s;
    logic [BW-1:0]                next_cnt_s;
    logic                         frame_err_s;

    // Running argmax update for the beat currently offered.
    always_comb begin
        accept_s    = score_valid && score_ready;
        next_best_s = best_r;
        next_idx_s  = best_idx_r;
        next_ovf_s  = ovf_r;
        if (beat_cnt_r == BW'(0)) begin
            next_best_s = score_data;
            next_idx_s  = {IDX_WIDTH{1'b0}};
        end else if (beat_cnt_r < BW'(NUM_CLASSES)) begin
            // Strict compare so ties keep the lower index.
            if (score_data > best_r) begin
                next_best_s = score_data;
                next_idx_s  = IDX_WIDTH'(beat_cnt_r);
            end else begin
                next_best_s = best_r;
            end
        end else begin
            next_ovf_s = 1'b1;
        end
        if (beat_cnt_r == BW'(NUM_CLASSES + 1)) begin
            next_cnt_s = beat_cnt_r;
        end else begin
            next_cnt_s = beat_cnt_r + BW'(1);
        end
        frame_err_s = next_ovf_s || (beat_cnt_r != BW'(NUM_CLASSES - 1));
    end

    // Frame FSM, accumulator state and registered result port.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_r     <= ACCUM;
            beat_cnt_r  <= {BW{1'b0}};
            best_r      <= {DATA_WIDTH{1'b0}};
            best_idx_r  <= {IDX_WIDTH{1'b0}};
            ovf_r       <= 1'b0;
            score_ready <= 1'b0;
            class_valid <= 1'b0;
            class_idx   <= {IDX_WIDTH{1'b0}};
            class_score <= {DATA_WIDTH{1'b0}};
            class_err   <= 1'b0;
            frame_count <= {CNT_WIDTH{1'b0}};
        end else begin
            case (state_r)
                ACCUM: begin
                    class_valid <= 1'b0;
                    score_ready <= 1'b1;
                    if (accept_s) begin
                        best_r     <= next_best_s;
                        best_idx_r <= next_idx_s;
                        ovf_r      <= next_ovf_s;
                        beat_cnt_r <= next_cnt_s;
                        if (score_last) begin
                            state_r     <= HOLD;
                            score_ready <= 1'b0;
                            class_valid <= 1'b1;
                            class_idx   <= next_idx_s;
                            class_score <= next_best_s;
                            class_err   <= frame_err_s;
                        end else begin
                            state_r <= ACCUM;
                        end
                    end else begin
                        state_r <= ACCUM;
                    end
                end
                HOLD: begin
                    if (class_valid && class_ready) begin
                        state_r     <= ACCUM;
                        class_valid <= 1'b0;
                        score_ready <= 1'b1;
                        frame_count <= frame_count + CNT_WIDTH'(1);
                        beat_cnt_r  <= {BW{1'b0}};
                        best_r      <= {DATA_WIDTH{1'b0}};
                        best_idx_r  <= {IDX_WIDTH{1'b0}};
                        ovf_r       <= 1'b0;
                    end else begin
                        score_ready <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ACCUM;
                    class_valid <= 1'b0;
                    score_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_class_decoder.sv
// Directed bench for cnn_class_decoder; the frame counter is narrowed to
// two bits so the wrap can be reached quickly.
module tb_cnn_class_decoder;

    logic               clk = 1'b0;
    logic               rstb;
    logic               score_valid;
    logic               score_ready;
    logic signed [31:0] score_data;
    logic               score_last;
    logic               class_valid;
    logic               class_ready;
    logic [3:0]         class_idx;
    logic [31:0]        class_score;
    logic               class_err;
    logic [1:0]         frame_count;

    int tests  = 0;
    int failed = 0;
    logic [1:0] fc_exp = 2'd0;
    logic signed [31:0] sc [0:15];

    always #5 clk = ~clk;

    cnn_class_decoder #(
        .NUM_CLASSES(10), .DATA_WIDTH(32), .IDX_WIDTH(4), .CNT_WIDTH(2)
    ) dut (
        .clk(clk), .rstb(rstb),
        .score_valid(score_valid), .score_ready(score_ready),
        .score_data(score_data), .score_last(score_last),
        .class_valid(class_valid), .class_ready(class_ready),
        .class_idx(class_idx), .class_score(class_score),
        .class_err(class_err), .frame_count(frame_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one beat and hold it until accepted (bounded wait).
    task automatic send(input logic signed [31:0] d, input logic l);
        int t;
        score_valid = 1'b1;
        score_data  = d;
        score_last  = l;
        t = 0;
        while (!score_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t == 50) chk("ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        score_valid = 1'b0;
        score_last  = 1'b0;
        score_data  = 32'hDEAD_BEEF;
    endtask

    task automatic frame(input int n);
        for (int i = 0; i < n; i++) send(sc[i], (i == n - 1));
    endtask

    // Result must be visible right after the last beat; then consume it.
    task automatic take(input string tag, input logic [3:0] idx, input logic [31:0] s, input logic err);
        chk({tag, "_valid"}, {31'd0, class_valid}, 32'd1);
        chk({tag, "_idx"},   {28'd0, class_idx}, {28'd0, idx});
        chk({tag, "_score"}, class_score, s);
        chk({tag, "_err"},   {31'd0, class_err}, {31'd0, err});
        class_ready = 1'b1;
        @(posedge clk); #1;
        class_ready = 1'b0;
        fc_exp = fc_exp + 2'd1;
        chk({tag, "_valid_drop"}, {31'd0, class_valid}, 32'd0);
        chk({tag, "_fcount"}, {30'd0, frame_count}, {30'd0, fc_exp});
        chk({tag, "_ready_back"}, {31'd0, score_ready}, 32'd1);
    endtask

    task automatic load10(input int a0, a1, a2, a3, a4, a5, a6, a7, a8, a9);
        sc[0] = a0; sc[1] = a1; sc[2] = a2; sc[3] = a3; sc[4] = a4;
        sc[5] = a5; sc[6] = a6; sc[7] = a7; sc[8] = a8; sc[9] = a9;
    endtask

    initial begin
        int bad;
        logic [31:0] held_score;
        rstb = 1'b0; score_valid = 1'b0; score_data = 32'sd0;
        score_last = 1'b0; class_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, class_valid}, 32'd0);
        chk("rst_ready", {31'd0, score_ready}, 32'd0);
        chk("rst_fcount", {30'd0, frame_count}, 32'd0);
        chk("rst_idx", {28'd0, class_idx}, 32'd0);
        chk("rst_score", class_score, 32'd0);
        chk("rst_err", {31'd0, class_err}, 32'd0);
        rstb = 1'b1;

        // Invalid beats with last asserted must be ignored.
        score_data = 32'sd999; score_last = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        score_last = 1'b0;
        chk("ignore_invalid", {31'd0, class_valid}, 32'd0);

        load10(5, 3, 9, -1, 9, 0, 2, 8, 7, 6);
        frame(10);
        take("basic", 4'd2, 32'd9, 1'b0);

        load10(-8, -3, -100, -3, -7, -9, 0, -5, -4, -6);
        sc[6] = 32'sh8000_0000;
        frame(10);
        take("negative", 4'd1, 32'hFFFF_FFFD, 1'b0);

        for (int i = 0; i < 10; i++) sc[i] = 32'sh8000_0000;
        sc[7] = 32'sh8000_0001;
        frame(10);
        take("min_value", 4'd7, 32'h8000_0001, 1'b0);

        // Backpressure: result held for 20 cycles with beats offered.
        load10(1, 2, 3, 4, 5, 6, 7, 8, 9, 10);
        frame(10);
        held_score = class_score;
        bad = 0;
        score_valid = 1'b1; score_data = 32'sd77;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (score_ready !== 1'b0 || class_valid !== 1'b1 ||
                class_idx !== 4'd9 || class_score !== held_score) bad++;
        end
        score_valid = 1'b0;
        chk("bp_stable", bad, 32'd0);
        take("bp", 4'd9, 32'd10, 1'b0);
        @(posedge clk); #1;
        chk("bp_single_result", {31'd0, class_valid}, 32'd0);

        load10(4, -2, 11, 3, 11, 0, 1, 0, 0, 0);
        frame(7);
        take("short", 4'd2, 32'd11, 1'b1);

        load10(1, 2, 3, 4, 5, 6, 7, 8, 9, 10);
        sc[10] = 32'sd50; sc[11] = 32'sd60;
        frame(12);
        take("long", 4'd9, 32'd10, 1'b1);

        sc[0] = -32'sd42;
        frame(1);
        take("single", 4'd0, 32'hFFFF_FFD6, 1'b1);

        // Reset after beat 4 of a frame discards it and clears the count.
        for (int i = 0; i < 5; i++) send(32'sd100 + i, 1'b0);
        rstb = 1'b0;
        @(posedge clk); #1;
        rstb = 1'b1;
        fc_exp = 2'd0;
        chk("midrst_fcount", {30'd0, frame_count}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_no_valid", {31'd0, class_valid}, 32'd0);
        load10(0, 4, -6, 12, 3, 12, 7, -1, 2, 11);
        frame(10);
        take("midrst", 4'd3, 32'd12, 1'b0);

        // Four more frames: counter runs 2,3,0,1.
        for (int f = 0; f < 4; f++) begin
            load10(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            sc[f] = 32'sd20 + f;
            frame(10);
            take("wrap", 4'(f), 32'd20 + f, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/cnn_class_decoder.md
Name: cnn_class_decoder

Overview:
- Sits at the output end of the cnn datapath. It consumes the fully-connected layer's per-class scores as a valid/ready stream and decodes the winning class (signed argmax).
- Presents the class index, its score and a frame-error flag on a valid/ready result port for the bench or downstream logic.
- Counts completed frames so multi-image runs can be checked against the input image count.

Parameters:
- NUM_CLASSES, 10, scores per frame; equals the fully-connected layer count.
- DATA_WIDTH, 32, score width; two's-complement signed.
- IDX_WIDTH, 4, class index width; must satisfy 2^IDX_WIDTH > NUM_CLASSES.
- CNT_WIDTH, 16, frame counter width.

Ports:
- clk  input  1  clock; all logic updates on the rising edge.
- rstb  input  1  reset, synchronous, active-low.
- score_valid  input  1  a score beat is offered.
- score_ready  output  1  the block can accept a score beat.
- score_data  input  DATA_WIDTH  signed class score; beats arrive in class order 0,1,2,...
- score_last  input  1  marks the final beat of a frame.
- class_valid  output  1  a decoded result is held on the result port.
- class_ready  input  1  downstream accepts the result.
- class_idx  output  IDX_WIDTH  index of the maximum score.
- class_score  output  DATA_WIDTH  value of the maximum score.
- class_err  output  1  the frame beat count was not equal to NUM_CLASSES.
- frame_count  output  CNT_WIDTH  number of results consumed; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset (rstb=0 at a clk edge):
  - state=ACCUM, beat counter=0, best=0, best_idx=0.
  - class_valid=0, class_idx=0, class_score=0, class_err=0, frame_count=0, score_ready=0 during the reset cycle.
  - Reset mid-frame or mid-HOLD discards all partial state. No result is emitted for that frame.
- State ACCUM:
  - score_ready=1 and class_valid=0.
  - A beat is accepted when score_valid and score_ready are both 1.
- Per accepted beat, with beat counter n:
  - n==0: best<=score_data, best_idx<=0.
  - 0<n<NUM_CLASSES: if score_data is signed-greater-than best (strict), then best<=score_data and best_idx<=n. Ties keep the lower index.
  - n>=NUM_CLASSES: the beat is consumed but not compared, and the overflow flag is set.
  - The counter increments and saturates at NUM_CLASSES+1.
- Accepted beat with score_last=1:
  - Moves to HOLD on the next edge.
  - The comparison for that beat is included.
  - class_idx and class_score load from the final best values.
  - class_err<=1 if total beats != NUM_CLASSES (short or long frame).
  - class_valid=1 from the cycle after the last beat. Latency from last beat to result is 1 cycle.
- State HOLD:
  - score_ready=0, so input is backpressured.
  - class_idx, class_score and class_err are stable while class_valid=1 and class_ready=0.
  - On class_valid and class_ready: next edge class_valid=0, frame_count increments, counter/best clear, state returns to ACCUM.
  - This gives one mandatory bubble cycle: score_ready=1 only from the cycle after the handshake.
- A single-beat frame (score_last on beat 0) produces class_idx=0, class_score=that beat, class_err=1.
- score_data with score_valid=0 is ignored regardless of value. score_last without score_valid is ignored.
- Comparison is full DATA_WIDTH signed: 32'h80000000 is the minimum and loses to every other value.
- frame_count wraps from 2^CNT_WIDTH-1 to 0 with no flag.
- Outputs are registered; no combinational path from inputs to class_* outputs. score_ready depends only on state.

Test Plan:
- Reset then 10 beats: scores 5,3,9,-1,9,0,2,8,7,last=6 -> class_valid 1 cycle after the last beat; class_idx=2, class_score=9 (tie at 4 loses), class_err=0. Hold class_ready=1 -> frame_count=1 and score_ready=1 one cycle later.
- All-negative frame -8,-3,-100,-3,-7,-9,-2^31,-5,-4,-6 with last on beat 9 -> class_idx=1, class_score=-3, class_err=0.
- Backpressure: complete a frame, hold class_ready=0 for 20 cycles while score_valid=1 -> score_ready=0 throughout; outputs stable; no beats consumed. Release -> exactly one result and frame_count+1.
- Length errors:
  - score_last on beat 6 (7 beats) -> class_err=1, argmax over those 7 beats.
  - 12 beats with last on 12th -> class_err=1, argmax over the first 10 only.
- Reset mid-frame: assert rstb=0 for 1 cycle after beat 4 -> no class_valid; the next clean 10-beat frame decodes correctly and frame_count=1.
- Counter wrap with CNT_WIDTH=2: 5 frames consumed -> frame_count sequence 1,2,3,0,1.
